// File: rtl/unbased_fill_pkg.sv
// Shared types for the fill-pattern stream checker.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package unbased_fill_pkg;

  // Expected-pattern selector, encoded to match the cfg_mode input.
  typedef enum logic [1:0] {
    FILL_ZERO      = 2'd0,
    FILL_ONES      = 2'd1,
    FILL_CAST_ONES = 2'd2,
    FILL_VALUE     = 2'd3
  } fill_mode_e;

  // Checker control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

endpackage : unbased_fill_pkg

// File: rtl/fill_pattern_gen.sv
// Expected-word generator: maps a fill mode (and literal value) to a WIDTH-bit pattern.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module fill_pattern_gen
  import unbased_fill_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CAST_W = 3
) (
  input  fill_mode_e       mode,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] pattern
);

  // Fills are width-agnostic: '0/'1 stretch to WIDTH, and the narrow cast
  // fill is CAST_W ones zero-extended to WIDTH.
  always_comb begin
    pattern = '0;
    case (mode)
      FILL_ZERO:      pattern = '0;
      FILL_ONES:      pattern = '1;
      FILL_CAST_ONES: pattern = WIDTH'(CAST_W'('1));
      FILL_VALUE:     pattern = value;
      default:        pattern = '0;
    endcase
  end

endmodule : fill_pattern_gen

// File: rtl/fill_stream_checker.sv
// Checks a run of cfg_len words against a latched fill pattern; reports counts, first error and pass.
// Latency: counts update 1 cycle after each accept; done pulses 1 cycle after the final accept.
// Backpressure: in_ready is high for the whole RUN state, so every valid word in RUN is accepted.
module fill_stream_checker
  import unbased_fill_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CAST_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  chk_state_e       state, state_nxt;
  fill_mode_e       mode_q;
  logic [WIDTH-1:0] value_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] word_idx;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             word_ok;
  logic             last_word;
  logic             start_run;

  fill_pattern_gen #(
    .WIDTH  (WIDTH),
    .CAST_W (CAST_W)
  ) u_pattern (
    .mode    (mode_q),
    .value   (value_q),
    .pattern (expected)
  );

  assign in_ready  = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign start_run = (state == ST_IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign word_ok   = (in_data == expected);
  // len_q is never zero while in RUN, so len_q-1 does not wrap there.
  assign last_word = (word_idx == len_q - CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: zero-length runs skip straight to DONE; DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (accept && last_word) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run configuration, latched only when a run starts so later cfg changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= FILL_ZERO;
      value_q <= '0;
      len_q   <= '0;
    end else if (start_run) begin
      mode_q  <= fill_mode_e'(cfg_mode);
      value_q <= cfg_value;
      len_q   <= cfg_len;
    end
  end

  // Per-run statistics: saturating counts, first-error capture and the pass verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx       <= '0;
      match_cnt      <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
    end else if (start_run) begin
      word_idx       <= '0;
      match_cnt      <= '0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      // An empty run has nothing to fail, so it reports pass in its DONE cycle.
      pass           <= (cfg_len == '0);
    end else if (accept) begin
      word_idx <= word_idx + CNT_W'(1);
      if (word_ok) begin
        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
      end else begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        // err_cnt saturates and never returns to zero, so zero means no error yet.
        if (err_cnt == '0) begin
          first_err_idx  <= word_idx;
          first_err_data <= in_data;
        end
      end
      // Verdict includes the final word so pass is valid during the done pulse.
      if (last_word) pass <= (err_cnt == '0) && word_ok;
    end
  end

endmodule : fill_stream_checker

// File: tb/tb_fill_stream_checker.sv
module tb_fill_stream_checker;

  localparam int WIDTH  = 64;
  localparam int CAST_W = 3;
  localparam int CNT_W  = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_value;
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_data;

  int checks;
  int failures;
  int done_cnt;
  int acc_cnt;

  fill_stream_checker #(
    .WIDTH  (WIDTH),
    .CAST_W (CAST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_mode       (cfg_mode),
    .cfg_value      (cfg_value),
    .cfg_len        (cfg_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .match_cnt      (match_cnt),
    .err_cnt        (err_cnt),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are stable at the falling edge, so this sees exactly what the next rising edge sees.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (in_valid && in_ready) acc_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] mode, input logic [WIDTH-1:0] value, input logic [CNT_W-1:0] len);
    cfg_mode  = mode;
    cfg_value = value;
    cfg_len   = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", pass); end
    checks++; if (match_cnt !== '0 || err_cnt !== '0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", match_cnt, err_cnt); end
    checks++; if (first_err_idx !== '0 || first_err_data !== '0) begin failures++; $display("FAIL reset_first_err got=%0d/%0h exp=0/0", first_err_idx, first_err_data); end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_zero_fill();
    launch(2'd0, '0, 16'd4);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL zero_run_state got=%0b/%0b exp=1/1", in_ready, busy); end
    in_valid = 1'b1;
    in_data  = '0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_early_done got=%0b exp=0", done); end
    step();
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b exp=1", done); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%0b exp=1", pass); end
    checks++; if (match_cnt !== 16'd4 || err_cnt !== 16'd0) begin failures++; $display("FAIL zero_counts got=%0d/%0d exp=4/0", match_cnt, err_cnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL zero_done_ready got=%0b exp=0", in_ready); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_back_idle got=%0b/%0b exp=0/0", done, busy); end
    checks++; if (pass !== 1'b1 || match_cnt !== 16'd4) begin failures++; $display("FAIL zero_hold got=%0b/%0d exp=1/4", pass, match_cnt); end
  endtask

  task automatic test_cast_fill();
    logic [WIDTH-1:0] words [3];
    words[0] = 64'h7;
    words[1] = 64'hF;
    words[2] = 64'h7;
    launch(2'd2, '0, 16'd3);
    checks++; if (pass !== 1'b0 || match_cnt !== '0) begin failures++; $display("FAIL cast_start_clear got=%0b/%0d exp=0/0", pass, match_cnt); end
    // Config changes after the latch must not affect the run.
    cfg_mode = 2'd0;
    cfg_len  = 16'd1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      step();
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL cast_done got=%0b exp=1", done); end
    checks++; if (err_cnt !== 16'd1 || match_cnt !== 16'd2) begin failures++; $display("FAIL cast_counts got=%0d/%0d exp=1/2", err_cnt, match_cnt); end
    checks++; if (first_err_idx !== 16'd1) begin failures++; $display("FAIL cast_first_idx got=%0d exp=1", first_err_idx); end
    checks++; if (first_err_data !== 64'hF) begin failures++; $display("FAIL cast_first_data got=%0h exp=f", first_err_data); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL cast_pass got=%0b exp=0", pass); end
    step();
  endtask

  task automatic test_toggle_valid();
    int d0;
    d0      = done_cnt;
    acc_cnt = 0;
    launch(2'd1, '0, 16'd3);
    in_data = '1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      step();
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL toggle_done got=%0b exp=1", done); end
    checks++; if (match_cnt !== 16'd3 || err_cnt !== 16'd0) begin failures++; $display("FAIL toggle_counts got=%0d/%0d exp=3/0", match_cnt, err_cnt); end
    step();
    step();
    checks++; if (acc_cnt !== 3) begin failures++; $display("FAIL toggle_accepts got=%0d exp=3", acc_cnt); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL toggle_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_zero_len();
    int d0;
    d0 = done_cnt;
    launch(2'd0, '0, 16'd0);
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL zlen_done_pass got=%0b/%0b exp=1/1", done, pass); end
    checks++; if (match_cnt !== '0 || err_cnt !== '0) begin failures++; $display("FAIL zlen_counts got=%0d/%0d exp=0/0", match_cnt, err_cnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL zlen_ready got=%0b exp=0", in_ready); end
    // Start during DONE must be ignored.
    launch(2'd1, '0, 16'd2);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL zlen_restart_ignored got=%0b/%0b exp=0/0", busy, done); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zlen_stay_idle got=%0b exp=0", busy); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL zlen_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = done_cnt;
    launch(2'd3, 64'hDEADBEEF_00000000, 16'd4);
    in_valid = 1'b1;
    in_data  = 64'hDEADBEEF_00000000;
    step();
    step();
    checks++; if (match_cnt !== 16'd2) begin failures++; $display("FAIL abort_pre_count got=%0d exp=2", match_cnt); end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_async_state got=%0b/%0b/%0b exp=0/0/0", busy, in_ready, done); end
    checks++; if (match_cnt !== '0 || pass !== 1'b0) begin failures++; $display("FAIL abort_async_outputs got=%0d/%0b exp=0/0", match_cnt, pass); end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL abort_no_done got=%0d exp=%0d", done_cnt, d0); end
    launch(2'd3, 64'hDEADBEEF_00000000, 16'd2);
    in_valid = 1'b1;
    in_data  = 64'hDEADBEEF_00000000;
    step();
    in_data  = 64'hDEADBEEF_00000001;
    step();
    in_valid = 1'b0;
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL abort_rerun_done got=%0b/%0b exp=1/0", done, pass); end
    checks++; if (match_cnt !== 16'd1 || err_cnt !== 16'd1) begin failures++; $display("FAIL abort_rerun_counts got=%0d/%0d exp=1/1", match_cnt, err_cnt); end
    checks++; if (first_err_idx !== 16'd1 || first_err_data !== 64'hDEADBEEF_00000001) begin failures++; $display("FAIL abort_rerun_first got=%0d/%0h exp=1/deadbeef00000001", first_err_idx, first_err_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [3];
    words[0] = 64'h5;
    words[1] = 64'h0;
    words[2] = 64'h9;
    // Starts in the first IDLE cycle after the previous run.
    launch(2'd0, '0, 16'd3);
    checks++; if (busy !== 1'b1 || first_err_data !== '0) begin failures++; $display("FAIL b2b_start got=%0b/%0h exp=1/0", busy, first_err_data); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      step();
    end
    in_valid = 1'b0;
    checks++; if (err_cnt !== 16'd2 || match_cnt !== 16'd1) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=2/1", err_cnt, match_cnt); end
    checks++; if (first_err_idx !== 16'd0 || first_err_data !== 64'h5) begin failures++; $display("FAIL b2b_first_kept got=%0d/%0h exp=0/5", first_err_idx, first_err_data); end
    step();
    checks++; if (first_err_data !== 64'h5 || err_cnt !== 16'd2) begin failures++; $display("FAIL b2b_idle_hold got=%0h/%0d exp=5/2", first_err_data, err_cnt); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    acc_cnt   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_mode  = 2'd0;
    cfg_value = '0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    test_reset();
    test_zero_fill();
    test_cast_fill();
    test_toggle_valid();
    test_zero_len();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fill_stream_checker
